// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic/compare operations and
// iterative shifts (one bit position per cycle), with valid/ready handshakes
// on both the operation input and the result output.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_SLT = 4'b1101
    } op_e;

    // Shift flavour kept while iterating; matches the low bits of the shift codes.
    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_SRL  = 2'b01,
        SH_SLL  = 2'b10,
        SH_SRA  = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e           state, state_next;
    shift_e           shift_op;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    count;

    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    logic             is_shift;
    logic [SW-1:0]    amount;
    logic             accept;
    logic [WIDTH-1:0] shift_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign amount    = src_b[SW-1:0];
    assign is_shift  = (operation == OP_SRL) || (operation == OP_SLL) || (operation == OP_SRA);

    // Single-cycle datapath; a shift reaching here only matters when its amount is 0.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (operation)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SRL,
            OP_SLL,
            OP_SRA:  alu_res = src_a;
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (src_a == src_b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_legal = 1'b0;
        endcase
    end

    // One-position shift of the working register.
    always_comb begin
        shift_next = shreg;
        case (shift_op)
            SH_SRL:  shift_next = {1'b0, shreg[WIDTH-1:1]};
            SH_SLL:  shift_next = {shreg[WIDTH-2:0], 1'b0};
            SH_SRA:  shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            default: shift_next = shreg;
        endcase
    end

    // Next-state logic for the IDLE / SHIFT / DONE sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (is_shift && (amount != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count == SW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, shift iteration and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_op   <= SH_NONE;
            shreg      <= '0;
            count      <= '0;
            result     <= '0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            if (accept) begin
                illegal_op <= ~alu_legal;
                if (is_shift && (amount != '0)) begin
                    shift_op <= shift_e'(operation[1:0]);
                    shreg    <= src_a;
                    count    <= amount;
                end else begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                end
            end else if (state == SHIFT) begin
                shreg <= shift_next;
                count <= count - SW'(1);
                if (count == SW'(1)) begin
                    result <= shift_next;
                    zero   <= (shift_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, random operations
// against a behavioural model, backpressure, back-to-back issue and reset.
module tb_alu_exec_unit;

    localparam int WIDTH  = 32;
    localparam int BUDGET = 60;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal_op;

    int n_checks = 0;
    int n_fails  = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result and illegal flag straight from the opcode table.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, output logic ill);
        int s;
        s   = int'(b % WIDTH);
        ill = 1'b0;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0100: return a - b;
            4'b0101: return a >> s;
            4'b0110: return a << s;
            4'b0111: return WIDTH'($signed(a) >>> s);
            4'b1000: return (a == b) ? 1 : 0;
            4'b1101: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: begin
                ill = 1'b1;
                return 0;
            end
        endcase
    endfunction

    // Edges after the accept edge before out_valid is seen.
    function automatic int ref_latency(input logic [3:0] op, input logic [WIDTH-1:0] b);
        if ((op == 4'b0101 || op == 4'b0110 || op == 4'b0111) && (b % WIDTH) != 0)
            return int'(b % WIDTH);
        return 0;
    endfunction

    // Issue one op with out_ready high, check latency/result/flags and the return to idle.
    task automatic do_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input string name);
        logic [WIDTH-1:0] exp_res;
        logic             exp_ill;
        int               exp_lat;
        int               lat;
        exp_res = ref_alu(op, a, b, exp_ill);
        exp_lat = ref_latency(op, b);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = op;
        src_a     = a;
        src_b     = b;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s in_ready before issue: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'($urandom);
        src_a     = $urandom;
        src_b     = $urandom;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL %s in_ready after accept: got %b want 0", name, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fails++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (result !== exp_res || zero !== (exp_res == 0) || illegal_op !== exp_ill) begin
            n_fails++;
            $display("FAIL %s result/zero/illegal: got %h/%b/%b want %h/%b/%b", name, result, zero,
                     illegal_op, exp_res, (exp_res == 0), exp_ill);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s return to idle: got out_valid=%b in_ready=%b want 0/1", name,
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = '0;
        src_a     = '0;
        src_b     = '0;
        #12;
        n_checks++;
        if (result !== '0 || zero !== 1'b0 || illegal_op !== 1'b0 || out_valid !== 1'b0 ||
            in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset state: got res=%h z=%b ill=%b ov=%b ir=%b want 0/0/0/0/1", result,
                     zero, illegal_op, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        do_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, "add_wrap");
        do_op(4'b0100, 32'd5, 32'd5, "sub_zero");
        do_op(4'b0111, 32'h8000_0000, 32'h0000_003F, "sra_31");
        do_op(4'b0110, 32'hDEAD_BEEF, 32'h0000_0020, "sll_0");
        do_op(4'b0101, 32'h8000_0001, 32'h0000_0001, "srl_1");
        do_op(4'b1101, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        do_op(4'b1101, 32'd1, 32'hFFFF_FFFF, "slt_pos");
        do_op(4'b1000, 32'h1234, 32'h1234, "eq_same");
        do_op(4'b1000, 32'h1234, 32'h1235, "eq_diff");
    endtask

    task automatic test_illegal;
        do_op(4'b1010, $urandom, $urandom, "illegal_1010");
        do_op(4'b0001, 32'hF0, 32'h0F, "or_after_illegal");
    endtask

    task automatic test_random;
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            do_op(op, $urandom, $urandom, $sformatf("rand%0d_op%h", i, op));
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        operation = 4'b0010;
        src_a     = 32'd3;
        src_b     = 32'd4;
        @(posedge clk);
        #1;
        operation = 4'b0011;
        src_a     = 32'hFFFF_0000;
        src_b     = 32'h0000_FFFF;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) begin
                n_fails++;
                $display("FAIL stall cycle %0d: got res=%h ov=%b ir=%b z=%b want 7/1/0/0", k,
                         result, out_valid, in_ready, zero);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL stall release: got ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL stall no queued op: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = 4'b0011;
        src_a     = 32'hA5A5_0F0F;
        src_b     = 32'h0F0F_A5A5;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== ((k % 2) == 0) ||
                (out_valid === 1'b1 && result !== 32'hAAAA_AAAA)) begin
                n_fails++;
                $display("FAIL back_to_back cycle %0d: got ov=%b res=%h want ov=%b res=aaaaaaaa", k,
                         out_valid, result, ((k % 2) == 0));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_midshift;
        bit seen;
        do_op(4'b0001, 32'hF0, 32'h0F, "or_before_reset");
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'b0101;
        src_a     = 32'hFFFF_FFFF;
        src_b     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== '0 || zero !== 1'b0 || illegal_op !== 1'b0 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset mid-shift: got res=%h z=%b ill=%b ov=%b want all 0", result, zero,
                     illegal_op, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset release in_ready: got %b want 1", in_ready);
        end
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fails++;
            $display("FAIL reset stale out_valid: got seen=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midshift();
        do_op(4'b0010, 32'd3, 32'd4, "add_after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution end of the ALU operation interface: consumes the 4-bit Operation code produced by instruction decode and performs the operation on two operands.
- Shifts are iterative, one bit position per cycle; all other operations complete in one cycle.
- Sits in the execute stage. Uses a valid/ready handshake on the input side and on the result side so that a multi-cycle shift can stall the pipeline.

Parameters:
- WIDTH, 32, operand and result width in bits; power of two, ≥ 8. Shift amount width SW = clog2(WIDTH), derived internally.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation and operands present
- in_ready  output  1  unit can accept a new operation
- operation  input  4  ALU operation code (encoding below)
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B; src_b[SW-1:0] is the shift amount
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered, result == 0
- illegal_op  output  1  registered, unsupported code was accepted

Behaviour:
- Encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SUB
  - 0101 SRL
  - 0110 SLL
  - 0111 SRA
  - 1000 EQ (result = 1 if src_a == src_b, else 0)
  - 1101 SLT (signed, result = 1 or 0)
  - All other codes are illegal.
- Arithmetic: ADD/SUB are modulo 2^WIDTH, with no carry or overflow output. Shifts use only src_b[SW-1:0]; upper bits of src_b are ignored.
- Reset (asynchronous, rst_n = 0):
  - state = IDLE
  - result = 0, zero = 0, illegal_op = 0, out_valid = 0
  - internal counter and shift register = 0
  - in_ready goes to 1 once state is IDLE.
- FSM states: IDLE, SHIFT, DONE.
- Input handshake: in_ready = (state == IDLE). An operation is accepted on a rising edge where in_valid && in_ready. The operation, src_a and shift amount are captured at that edge; inputs are don't-care afterwards.
- IDLE, on accept:
  - Non-shift op, or shift with amount 0: result, zero and illegal_op are registered at the accept edge and the FSM goes to DONE. out_valid is high in the cycle after acceptance (latency 1).
  - Shift with amount s > 0: shift register = src_a, count = s, go to SHIFT.
- SHIFT: on each edge, shift by one position (SRL fills 0, SLL fills 0, SRA replicates the MSB) and decrement count. On the edge where count goes 1 → 0, the shifted value is written to result, zero is updated, and the FSM goes to DONE. out_valid rises s cycles after the accept edge.
- DONE:
  - out_valid = 1; result, zero and illegal_op are held stable while out_ready = 0.
  - On an edge where out_ready = 1, out_valid drops and the FSM goes to IDLE.
  - There is no same-cycle new accept: the minimum issue interval is 2 cycles.
- Illegal code: result = 0, zero = 1, illegal_op = 1, latency 1. illegal_op clears on the next accepted legal op.
- in_valid while busy: ignored, not queued. The producer must hold in_valid until in_ready.
- Reset mid-SHIFT or mid-DONE: the operation in flight is discarded immediately and no result is presented.
- out_ready while not in DONE: no effect.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000002, out_ready = 1 → out_valid 1 cycle after accept, result 0x00000001, zero = 0. SUB 5 − 5 → result 0, zero = 1.
- SRA src_a = 0x80000000, src_b = 0x0000003F (amount 31) → out_valid exactly 31 cycles after accept, result 0xFFFFFFFF. SLL amount 0 → latency 1, result = src_a.
- SLT src_a = 0xFFFFFFFF (−1), src_b = 1 → result 1. EQ 0x1234 vs 0x1234 → result 1. EQ 0x1234 vs 0x1235 → result 0.
- Backpressure: ADD 3 + 4 with out_ready = 0 for 5 cycles → result 7 stable, out_valid = 1 and in_ready = 0 throughout. A second in_valid during the stall is ignored. After out_ready, IDLE with in_ready = 1 on the next cycle.
- Reset: start SRL by 20 and assert rst_n = 0 at cycle 7 → all outputs 0 immediately (asynchronous). After release, in_ready = 1 and no stale out_valid appears.
- Illegal code 1010 → illegal_op = 1, result 0, zero = 1, latency 1. The next legal OR 0xF0 | 0x0F → result 0xFF, illegal_op = 0.
